// File: rtl/cv32e40p_voter_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_voter_pkg
// Shared types and the per-lane vote decision for the TMR voter/monitor.
//   NREP          : number of replicas (a, b, c)
//   replica_idx_e : replica index, also the bit position in flag/fail vectors
//   vote_mode_e   : TMR (all healthy) or DMR (one replica failed)
//   lane_vote()   : maps the three pairwise equalities of a lane to the
//                   selected source replica, the flagged replica and the
//                   unattributable indication
// -----------------------------------------------------------------------------
package cv32e40p_voter_pkg;

    localparam int NREP = 3;

    typedef enum logic [1:0] {
        REP_A = 2'd0,
        REP_B = 2'd1,
        REP_C = 2'd2
    } replica_idx_e;

    typedef enum logic {
        MODE_TMR = 1'b0,
        MODE_DMR = 1'b1
    } vote_mode_e;

    typedef struct packed {
        logic [NREP-1:0] flag;    // replica(s) disagreeing with the majority
        logic            unattr;  // all three differ
        replica_idx_e    sel;     // replica driving the lane output
    } lane_vote_t;

    // Priority b==c, then a==b, then a==c. When b==c the output is b even if
    // a also matches, so a is only flagged when it actually differs.
    function automatic lane_vote_t lane_vote(input logic eq_ab,
                                             input logic eq_bc,
                                             input logic eq_ac);
        lane_vote_t v;
        v.flag   = '0;
        v.unattr = 1'b0;
        v.sel    = REP_A;
        if (eq_bc) begin
            v.sel                = REP_B;
            v.flag[int'(REP_A)]  = ~eq_ab;
        end else if (eq_ab) begin
            v.flag[int'(REP_C)]  = 1'b1;
        end else if (eq_ac) begin
            v.flag[int'(REP_B)]  = 1'b1;
        end else begin
            v.unattr = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/cv32e40p_voter_lane.sv
// -----------------------------------------------------------------------------
// cv32e40p_voter_lane
// Combinational LW-bit majority vote of one lane.
//   a_i, b_i, c_i : replica lane data
//   out_o         : voted lane data (b when b==c, otherwise a)
//   flag_o        : replica flagged in this lane; bit0 = a, bit1 = b, bit2 = c
//   unattr_o      : all three replicas differ
// -----------------------------------------------------------------------------
module cv32e40p_voter_lane
    import cv32e40p_voter_pkg::*;
#(
    parameter int LW = 8
) (
    input  logic [LW-1:0]   a_i,
    input  logic [LW-1:0]   b_i,
    input  logic [LW-1:0]   c_i,
    output logic [LW-1:0]   out_o,
    output logic [NREP-1:0] flag_o,
    output logic            unattr_o
);

    lane_vote_t vote;

    assign vote     = lane_vote(a_i == b_i, b_i == c_i, a_i == c_i);
    assign out_o    = (vote.sel == REP_B) ? b_i : a_i;
    assign flag_o   = vote.flag;
    assign unattr_o = vote.unattr;

endmodule

// File: rtl/cv32e40p_tmr_voter_mon.sv
// -----------------------------------------------------------------------------
// cv32e40p_tmr_voter_mon
// Registered lane-granular TMR voter with per-replica health tracking. After
// FAULT_THR consecutive attributable mismatches a replica is marked failed and
// the voter degrades to a duplex compare of the two remaining replicas.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i             : replica data qualifier
//   data_{a,b,c}_i      : replica buses (NBIT, NLANE vote lanes)
//   clr_i               : clear fail mask, error counters, consecutive counts
//   valid_o, data_o     : registered valid and voted data (1 cycle latency)
//   err_{a,b,c}_o       : attributable mismatch pulse per replica
//   uncorr_o            : unattributable / uncorrectable mismatch pulse
//   fail_mask_o         : failed replicas; bit0 = a, bit1 = b, bit2 = c
//   err_cnt_o           : saturating error counters; [CNT_W-1:0] = a
// Optional (CV32E40P_VOTER_SYNDROME_EN):
//   syndrome_o          : lane syndrome of the first non-clean valid cycle
//                         after reset/clear; bit r*NLANE+L = replica r in lane L
//   syndrome_vld_o      : syndrome_o holds a captured value
// NBIT must be a multiple of NLANE.
// -----------------------------------------------------------------------------
module cv32e40p_tmr_voter_mon
    import cv32e40p_voter_pkg::*;
#(
    parameter int NBIT      = 32,
    parameter int NLANE     = 4,
    parameter int FAULT_THR = 4,
    parameter int CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [NBIT-1:0]       data_a_i,
    input  logic [NBIT-1:0]       data_b_i,
    input  logic [NBIT-1:0]       data_c_i,
    input  logic                  clr_i,
    output logic                  valid_o,
    output logic [NBIT-1:0]       data_o,
    output logic                  err_a_o,
    output logic                  err_b_o,
    output logic                  err_c_o,
    output logic                  uncorr_o,
    output logic [NREP-1:0]       fail_mask_o,
    output logic [NREP*CNT_W-1:0] err_cnt_o
`ifdef CV32E40P_VOTER_SYNDROME_EN
    ,
    output logic [NREP*NLANE-1:0] syndrome_o,
    output logic                  syndrome_vld_o
`endif
);

    localparam int LW = NBIT / NLANE;
    // Wide enough to hold FAULT_THR itself.
    localparam int CW = $clog2(FAULT_THR + 1);

    // ---------------------------------------------------------------- lanes
    logic [NBIT-1:0]                tmr_data;
    logic [NLANE-1:0][NREP-1:0]     lane_flag;
    logic [NLANE-1:0]               lane_unattr;

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        cv32e40p_voter_lane #(.LW(LW)) u_lane (
            .a_i      (data_a_i[l*LW +: LW]),
            .b_i      (data_b_i[l*LW +: LW]),
            .c_i      (data_c_i[l*LW +: LW]),
            .out_o    (tmr_data[l*LW +: LW]),
            .flag_o   (lane_flag[l]),
            .unattr_o (lane_unattr[l])
        );
    end

    // ---------------------------------------------------------------- state
    logic                        valid_q,     valid_d;
    logic [NBIT-1:0]             data_q,      data_d;
    logic [NREP-1:0]             err_q,       err_d;
    logic                        uncorr_q,    uncorr_d;
    logic [NREP-1:0]             fail_mask_q, fail_mask_d;
    logic [NREP-1:0][CNT_W-1:0]  cnt_q,       cnt_d;
    logic [NREP-1:0][CW-1:0]     cons_q,      cons_d;

    vote_mode_e      mode;
    logic [NREP-1:0] mis;
    logic            any_unattr;
    logic            tmr_uncorr;
    logic [NBIT-1:0] h_lo, h_hi;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        mis        = '0;
        any_unattr = |lane_unattr;
        for (int l = 0; l < NLANE; l++) begin
            mis = mis | lane_flag[l];
        end
        // Flags spread over several replicas cannot be blamed on one source.
        tmr_uncorr = any_unattr || ($countones(mis) > 1);

        mode = (fail_mask_q == '0) ? MODE_TMR : MODE_DMR;

        // Healthy pair in DMR; h_lo is the lower-index healthy replica.
        unique case (fail_mask_q)
            3'b001:  begin h_lo = data_b_i; h_hi = data_c_i; end
            3'b010:  begin h_lo = data_a_i; h_hi = data_c_i; end
            default: begin h_lo = data_a_i; h_hi = data_b_i; end
        endcase
    end

    always_comb begin
        valid_d     = valid_i;
        data_d      = data_q;
        err_d       = '0;
        uncorr_d    = 1'b0;
        fail_mask_d = fail_mask_q;
        cnt_d       = cnt_q;
        cons_d      = cons_q;

        if (valid_i) begin
            if (mode == MODE_TMR) begin
                data_d = tmr_data;
                if (tmr_uncorr) begin
                    uncorr_d = 1'b1;
                end else begin
                    err_d = mis;
                    for (int r = 0; r < NREP; r++) begin
                        if (mis[r]) begin
                            if (cnt_q[r] != '1) begin
                                cnt_d[r] = cnt_q[r] + CNT_W'(1);
                            end
                            cons_d[r] = cons_q[r] + CW'(1);
                            // At most one replica mismatches here, so at most
                            // one can fail per cycle.
                            if (cons_d[r] == CW'(FAULT_THR)) begin
                                fail_mask_d[r] = 1'b1;
                            end
                        end else begin
                            cons_d[r] = '0;
                        end
                    end
                end
            end else begin
                data_d   = h_lo;
                uncorr_d = (h_lo != h_hi);
            end
        end

        // Clear overrides any health update computed above; the data and
        // pulses of this cycle still go out under the old mask.
        if (clr_i) begin
            fail_mask_d = '0;
            cnt_d       = '0;
            cons_d      = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        // NOTE: counters are a handful of flops, not a RAM, so they are reset
        // along with everything else.
        if (rst_i) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= '0;
            uncorr_q    <= 1'b0;
            fail_mask_q <= '0;
            cnt_q       <= '0;
            cons_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            uncorr_q    <= uncorr_d;
            fail_mask_q <= fail_mask_d;
            cnt_q       <= cnt_d;
            cons_q      <= cons_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign err_a_o     = err_q[int'(REP_A)];
    assign err_b_o     = err_q[int'(REP_B)];
    assign err_c_o     = err_q[int'(REP_C)];
    assign uncorr_o    = uncorr_q;
    assign fail_mask_o = fail_mask_q;
    assign err_cnt_o   = cnt_q;

`ifdef CV32E40P_VOTER_SYNDROME_EN
    // ------------------------------------------------------------- syndrome
    logic [NREP*NLANE-1:0] syn_vec;
    logic [NREP*NLANE-1:0] syn_q, syn_d;
    logic                  syn_vld_q, syn_vld_d;

    always_comb begin
        syn_vec = '0;
        for (int r = 0; r < NREP; r++) begin
            for (int l = 0; l < NLANE; l++) begin
                syn_vec[r*NLANE + l] = lane_flag[l][r] | lane_unattr[l];
            end
        end

        syn_d     = syn_q;
        syn_vld_d = syn_vld_q;
        if (valid_i && !syn_vld_q && ((err_d != '0) || uncorr_d)) begin
            syn_d     = syn_vec;
            syn_vld_d = 1'b1;
        end
        if (clr_i) begin
            syn_d     = '0;
            syn_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            syn_q     <= '0;
            syn_vld_q <= 1'b0;
        end else begin
            syn_q     <= syn_d;
            syn_vld_q <= syn_vld_d;
        end
    end

    assign syndrome_o     = syn_q;
    assign syndrome_vld_o = syn_vld_q;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_voter_mon.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_tmr_voter_mon
// Directed bench for the TMR voter/monitor. The main instance uses default
// parameters; a second instance (CNT_W=2, FAULT_THR=8) shares the inputs and
// exercises counter saturation. Outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cv32e40p_tmr_voter_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] da, db, dc;
    logic        clr;

    logic        valid_o;
    logic [31:0] data_o;
    logic        err_a, err_b, err_c, uncorr;
    logic [2:0]  fail_mask;
    logic [23:0] err_cnt;

    logic        s_valid_o;
    logic [31:0] s_data_o;
    logic        s_err_a, s_err_b, s_err_c, s_uncorr;
    logic [2:0]  s_fail_mask;
    logic [5:0]  s_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cv32e40p_tmr_voter_mon dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .data_a_i    (da),
        .data_b_i    (db),
        .data_c_i    (dc),
        .clr_i       (clr),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .err_a_o     (err_a),
        .err_b_o     (err_b),
        .err_c_o     (err_c),
        .uncorr_o    (uncorr),
        .fail_mask_o (fail_mask),
        .err_cnt_o   (err_cnt)
    );

    cv32e40p_tmr_voter_mon #(.CNT_W(2), .FAULT_THR(8)) dut_sat (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .data_a_i    (da),
        .data_b_i    (db),
        .data_c_i    (dc),
        .clr_i       (clr),
        .valid_o     (s_valid_o),
        .data_o      (s_data_o),
        .err_a_o     (s_err_a),
        .err_b_o     (s_err_b),
        .err_c_o     (s_err_c),
        .uncorr_o    (s_uncorr),
        .fail_mask_o (s_fail_mask),
        .err_cnt_o   (s_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample just after the edge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic cl, input logic rs);
        valid = v;
        da    = a;
        db    = b;
        dc    = c;
        clr   = cl;
        rst   = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic v, input logic [31:0] d,
                            input logic [2:0] e, input logic u, input logic [2:0] fm,
                            input logic [23:0] cnt);
        check({tag, ".valid"},  64'(valid_o),                 64'(v));
        check({tag, ".data"},   64'(data_o),                  64'(d));
        check({tag, ".err"},    64'({err_c, err_b, err_a}),   64'(e));
        check({tag, ".uncorr"}, 64'(uncorr),                  64'(u));
        check({tag, ".fail"},   64'(fail_mask),               64'(fm));
        check({tag, ".cnt"},    64'(err_cnt),                 64'(cnt));
    endtask

    localparam logic [31:0] BEEF = 32'hDEADBEEF;
    localparam logic [31:0] BE00 = 32'hDEADBE00;
    localparam logic [31:0] BASE = 32'h11223344;
    localparam logic [31:0] CAFE = 32'hCAFEF00D;

    initial begin
        valid = 1'b0; da = '0; db = '0; dc = '0; clr = 1'b0; rst = 1'b1;

        // Reset
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        cyc(1'b1, BEEF, 1, 2, 1'b0, 1'b1);
        expect_o("reset", 1'b0, 32'h0, 3'b000, 1'b0, 3'b000, 24'h0);
        check("reset.sat_cnt", 64'(s_err_cnt), 64'h0);

        // Clean vote
        cyc(1'b1, BEEF, BEEF, BEEF, 1'b0, 1'b0);
        expect_o("clean", 1'b1, BEEF, 3'b000, 1'b0, 3'b000, 24'h0);

        // Lane-0 fault on a, then a clean cycle
        cyc(1'b1, BE00, BEEF, BEEF, 1'b0, 1'b0);
        expect_o("lane_fault", 1'b1, BEEF, 3'b001, 1'b0, 3'b000, 24'h000001);
        cyc(1'b1, BEEF, BEEF, BEEF, 1'b0, 1'b0);
        expect_o("post_fault", 1'b1, BEEF, 3'b000, 1'b0, 3'b000, 24'h000001);

        // Idle cycle: data holds, no pulses, no state update
        cyc(1'b0, 1, 2, 3, 1'b0, 1'b0);
        expect_o("idle", 1'b0, BEEF, 3'b000, 1'b0, 3'b000, 24'h000001);

        // All three differ in lane 0
        cyc(1'b1, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
        expect_o("unattr", 1'b1, 32'h1, 3'b000, 1'b1, 3'b000, 24'h000001);

        // a flagged in lane 0 and c flagged in lane 3
        cyc(1'b1, 32'h112233FF, BASE, 32'hFF223344, 1'b0, 1'b0);
        expect_o("multi", 1'b1, BASE, 3'b000, 1'b1, 3'b000, 24'h000001);

        // b corrupted in lane 2 for FAULT_THR=4 consecutive cycles
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, BASE, 32'h11DD3344, BASE, 1'b0, 1'b0);
            expect_o($sformatf("thr%0d", k), 1'b1, BASE, 3'b010, 1'b0,
                     (k == 4) ? 3'b010 : 3'b000, 24'h000001 | (24'(k) << 8));
        end

        // DMR on a/c
        cyc(1'b1, 32'h1, 32'h7, 32'h2, 1'b0, 1'b0);
        expect_o("dmr_neq", 1'b1, 32'h1, 3'b000, 1'b1, 3'b010, 24'h000401);
        cyc(1'b1, 32'h5, 32'h9, 32'h5, 1'b0, 1'b0);
        expect_o("dmr_eq", 1'b1, 32'h5, 3'b000, 1'b0, 3'b010, 24'h000401);

        // Clear while in DMR: voted under old mask (a vs c differ)
        cyc(1'b1, BE00, BEEF, BEEF, 1'b1, 1'b0);
        expect_o("clr_dmr", 1'b1, BE00, 3'b000, 1'b1, 3'b000, 24'h0);

        // Clear in TMR with a mismatch: pulse appears, counter stays cleared
        cyc(1'b1, BE00, BEEF, BEEF, 1'b1, 1'b0);
        expect_o("clr_tmr", 1'b1, BEEF, 3'b001, 1'b0, 3'b000, 24'h0);

        // Fail a, then clear with a mismatch on the healthy b/c pair
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, BE00, BEEF, BEEF, 1'b0, 1'b0);
            expect_o($sformatf("fail_a%0d", k), 1'b1, BEEF, 3'b001, 1'b0,
                     (k == 4) ? 3'b001 : 3'b000, 24'(k));
        end
        cyc(1'b1, BEEF, 32'h1, 32'h2, 1'b1, 1'b0);
        expect_o("clr_fail", 1'b1, 32'h1, 3'b000, 1'b1, 3'b000, 24'h0);

        // Reset mid-stream discards the in-flight result
        cyc(1'b1, BEEF, BEEF, BEEF, 1'b0, 1'b0);
        expect_o("pre_rst", 1'b1, BEEF, 3'b000, 1'b0, 3'b000, 24'h0);
        cyc(1'b1, BEEF, BEEF, BEEF, 1'b0, 1'b1);
        expect_o("rst_mid", 1'b0, 32'h0, 3'b000, 1'b0, 3'b000, 24'h0);

        // Isolated faults on c: CNT_W=2 counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, CAFE, CAFE, CAFE ^ 32'h1, 1'b0, 1'b0);
            check($sformatf("sat%0d.cnt_c", k), 64'(s_err_cnt[5:4]), 64'((k > 3) ? 3 : k));
            check($sformatf("sat%0d.err_c", k), 64'(s_err_c), 64'h1);
            check($sformatf("sat%0d.fail", k), 64'(s_fail_mask), 64'h0);
            check($sformatf("sat%0d.data", k), 64'(s_data_o), 64'(CAFE));
            expect_o($sformatf("iso%0d", k), 1'b1, CAFE, 3'b100, 1'b0, 3'b000, 24'(k) << 16);
            cyc(1'b1, CAFE, CAFE, CAFE, 1'b0, 1'b0);
            check($sformatf("sat%0d.clean", k), 64'(s_err_c), 64'h0);
        end
        check("sat.final_cnt", 64'(s_err_cnt), 64'h30);
        check("sat.final_fail", 64'(s_fail_mask), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
